nbit_register_file: RTL and testbench

Parameterised general-purpose register file for the CPU datapath: 2^select_width registers of data_width bits each.
- Two independent combinational read ports feed the ALU operands.
- One synchronous write port takes the writeback value.
- Register 0 is hardwired to zero (MIPS-style $zero).

---
 rtl/cpu_pkg.sv | 11 +
 rtl/nbit_register.sv | 37 +++
 rtl/nbit_register_file.sv | 48 ++++
 tb/tb_nbit_register_file.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, the hardwired zero register
// index and the register data type.
package cpu_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_SEL_WIDTH = 5;
    localparam int ZERO_REG      = 0;

    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/nbit_register.sv
// One register-file entry: a data_width-bit register with synchronous clear
// and a load enable. Clear takes priority over load.
import cpu_pkg::*;

module nbit_register #(
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [data_width-1:0] d_i,
    output logic [data_width-1:0] q_o
);

    logic [data_width-1:0] data_q;
    logic [data_width-1:0] data_d;

    // NOTE: data_d gets a default before the conditional update, so no latch is inferred.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : nbit_register

// File: rtl/nbit_register_file.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, and register 0 hardwired to zero.
import cpu_pkg::*;

module nbit_register_file #(
    parameter int data_width   = DATA_WIDTH,
    parameter int select_width = REG_SEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [data_width-1:0]   write_data,
    input  logic [select_width-1:0] write_address,
    input  logic                    RegWrite,
    input  logic [select_width-1:0] read_sel_1,
    input  logic [select_width-1:0] read_sel_2,
    output logic [data_width-1:0]   read_data_1,
    output logic [data_width-1:0]   read_data_2
);

    localparam int NUM_REGS = 2 ** select_width;

    logic [data_width-1:0] regs [NUM_REGS];

    // The zero register has no storage at all, so nothing can ever change it.
    assign regs[ZERO_REG] = '0;

    // NOTE: every entry is cleared by reset, so no read can ever return X from an unwritten register.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        logic load;

        assign load = RegWrite && (write_address == select_width'(i));

        nbit_register #(
            .data_width (data_width)
        ) u_reg (
            .clk    (clk),
            .rst    (rst),
            .load_i (load),
            .d_i    (write_data),
            .q_o    (regs[i])
        );
    end

    // No write-to-read bypass: a same-cycle write shows up only after the edge.
    assign read_data_1 = regs[read_sel_1];
    assign read_data_2 = regs[read_sel_2];

endmodule : nbit_register_file

// File: tb/tb_nbit_register_file.sv
// Self-checking bench for nbit_register_file: directed table, hand-written
// corner sequences and randomized traffic against an array-based model.
import cpu_pkg::*;

module tb_nbit_register_file;

    logic                     clk;
    logic                     rst;
    reg_data_t                write_data;
    logic [REG_SEL_WIDTH-1:0] write_address;
    logic                     RegWrite;
    logic [REG_SEL_WIDTH-1:0] read_sel_1;
    logic [REG_SEL_WIDTH-1:0] read_sel_2;
    reg_data_t                read_data_1;
    reg_data_t                read_data_2;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view of the register file.
    reg_data_t model [32];

    typedef struct {
        logic      rst;
        logic      we;
        logic [4:0] addr;
        reg_data_t data;
        logic [4:0] sel1;
        logic [4:0] sel2;
        reg_data_t exp1;
        reg_data_t exp2;
    } vec_t;

    vec_t vecs [7];

    nbit_register_file #(
        .data_width   (DATA_WIDTH),
        .select_width (REG_SEL_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_data    (write_data),
        .write_address (write_address),
        .RegWrite      (RegWrite),
        .read_sel_1    (read_sel_1),
        .read_sel_2    (read_sel_2),
        .read_data_1   (read_data_1),
        .read_data_2   (read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input reg_data_t actual, input reg_data_t expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic reg_data_t model_read(input logic [4:0] sel);
        return (sel == 5'd0) ? '0 : model[sel];
    endfunction

    // One clock: drive at negedge, check pre-edge reads, take the edge,
    // update the model from the rules, check post-edge reads.
    task automatic cycle(input logic r, input logic w, input logic [4:0] a,
                         input reg_data_t d, input logic [4:0] s1, input logic [4:0] s2);
        @(negedge clk);
        rst = r; RegWrite = w; write_address = a; write_data = d;
        read_sel_1 = s1; read_sel_2 = s2;
        #1;
        check("pre_edge_rd1", read_data_1, model_read(s1));
        check("pre_edge_rd2", read_data_2, model_read(s2));
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) model[k] = '0;
        end else if (w && a != 5'd0) begin
            model[a] = d;
        end
        #1;
        check("post_edge_rd1", read_data_1, model_read(s1));
        check("post_edge_rd2", read_data_2, model_read(s2));
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b0; RegWrite = 1'b0;
        write_address = '0; write_data = '0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0, 5'd31, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0};
        vecs[3] = '{1'b0, 1'b0, 5'd7,  32'h12345678, 5'd7, 5'd5,  32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 5'd31, 32'h00001234, 5'd31, 5'd7, 32'h00001234, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 5'd3,  32'hA5A5A5A5, 5'd3, 5'd5,  32'h0,        32'h0};
        vecs[6] = '{1'b0, 1'b1, 5'd3,  32'hA5A5A5A5, 5'd3, 5'd31, 32'hA5A5A5A5, 32'h0};

        rst = 1'b1; RegWrite = 1'b0; write_address = '0; write_data = '0;
        read_sel_1 = '0; read_sel_2 = '0;
        @(posedge clk);
        for (int k = 0; k < 32; k++) model[k] = '0;
        idle();

        // Reset sweep on both ports, no clock involvement needed.
        for (int i = 0; i < 32; i++) begin
            read_sel_1 = 5'(i); read_sel_2 = 5'(31 - i);
            #1;
            check("reset_sweep_rd1", read_data_1, 32'h0);
            check("reset_sweep_rd2", read_data_2, 32'h0);
        end

        foreach (vecs[v]) begin
            cycle(vecs[v].rst, vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].sel1, vecs[v].sel2);
            check($sformatf("vec%0d_rd1", v), read_data_1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), read_data_2, vecs[v].exp2);
        end

        // Same-cycle read/write of one register: old value before the edge.
        @(negedge clk);
        rst = 1'b0; RegWrite = 1'b1; write_address = 5'd9; write_data = 32'hCAFEF00D;
        read_sel_1 = 5'd9; read_sel_2 = 5'd3;
        #1;
        check("nobypass_before", read_data_1, 32'h0);
        @(posedge clk);
        model[9] = 32'hCAFEF00D;
        #1;
        check("nobypass_after", read_data_1, 32'hCAFEF00D);
        idle();

        // Reads follow select changes without a clock edge.
        read_sel_1 = 5'd3;
        #1 check("sel_follow_3", read_data_1, 32'hA5A5A5A5);
        read_sel_1 = 5'd9;
        #1 check("sel_follow_9", read_data_1, 32'hCAFEF00D);

        // Full sweep: write i*0x01010101 everywhere, read back pairwise.
        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 1'b1, 5'(i), reg_data_t'(i) * 32'h01010101, 5'(i), 5'(31 - i));
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            read_sel_1 = 5'(i); read_sel_2 = 5'(31 - i);
            #1;
            check("sweep_rd1", read_data_1, reg_data_t'(i) * 32'h01010101);
            check("sweep_rd2", read_data_2, reg_data_t'(31 - i) * 32'h01010101);
            read_sel_2 = 5'(i);
            #1;
            check("same_sel_rd2", read_data_2, reg_data_t'(i) * 32'h01010101);
        end

        // Reset mid-operation beats a simultaneous write and clears everything.
        cycle(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd17);
        idle();
        for (int i = 0; i < 32; i++) begin
            read_sel_1 = 5'(i); read_sel_2 = 5'(31 - i);
            #1;
            check("midreset_rd1", read_data_1, 32'h0);
            check("midreset_rd2", read_data_2, 32'h0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), reg_data_t'($urandom()),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nbit_register_file
